alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 77 +++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU; S1 holds operands, S2 holds the registered result and flags.
// Result bit WIDTH carries carry/borrow/shift-out; flags are {overflow, negative, carry, zero}.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result,
   output logic [3:0]       flags
);
   localparam int SW = $clog2(WIDTH);
   logic             s1_v, s1_adv, in_fire, ovf, zero;
   logic [WIDTH-1:0] s1_a, s1_b;
   logic [2:0]       s1_op;
   logic [WIDTH:0]   r;
   logic [SW-1:0]    sh;
   assign s1_adv   = s1_v && (!out_valid || out_ready);
   assign in_ready = !rst && (!s1_v || s1_adv);
   assign in_fire  = in_valid && in_ready;
   assign sh       = s1_b[SW-1:0];
   always_comb begin
      r   = '0;
      ovf = 1'b0;
      case (s1_op)
         3'd0: begin
            r   = {1'b0, s1_a} + {1'b0, s1_b};
            ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (r[WIDTH-1] != s1_a[WIDTH-1]);
         end
         3'd1: begin
            r   = {1'b0, s1_a} - {1'b0, s1_b};
            ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (r[WIDTH-1] != s1_a[WIDTH-1]);
         end
         3'd2: r = {1'b0, s1_a & s1_b};
         3'd3: r = {1'b0, s1_a | s1_b};
         3'd4: r = {1'b0, s1_a ^ s1_b};
         // widening by one bit lets the last bit shifted out land in bit WIDTH
         3'd5: r = {1'b0, s1_a} << sh;
         3'd6: r = {1'b0, s1_a >> sh};
         default: r = {{WIDTH{1'b0}}, s1_a < s1_b};
      endcase
      zero = (s1_op == 3'd7) ? (s1_a == s1_b) : (r[WIDTH-1:0] == '0);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v      <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_op     <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else begin
         if (in_fire) begin
            s1_v  <= 1'b1;
            s1_a  <= a;
            s1_b  <= b;
            s1_op <= op;
         end else if (s1_adv) begin
            s1_v <= 1'b0;
         end
         if (s1_adv) begin
            out_valid <= 1'b1;
            result    <= r;
            flags     <= {ovf, r[WIDTH-1], r[WIDTH], zero};
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule
